// File: rtl/memory_arbiter_pkg.sv
// Shared types and constants for the memory arbiter and its round-robin picker.
package MemoryArbiterPkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DATA = 2'd2
    } arb_state_e;

    localparam int WAIT_CNT_W = 8;

    // Successor of idx in a ring of n requesters.
    function automatic int next_index(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/memory_arbiter_if.sv
// Requester and main-memory signals of the arbiter, bundled with arbiter/driver views.
interface memory_arbiter_if #(
    parameter int NUM_REQUESTERS = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32
);
    logic [NUM_REQUESTERS-1:0]                 aRequest;
    logic [NUM_REQUESTERS-1:0][ADDR_WIDTH-1:0] aRequestAddr;
    logic [NUM_REQUESTERS-1:0]                 anOutGrant;
    logic [DATA_WIDTH-1:0]                     anOutReadData;
    logic [NUM_REQUESTERS-1:0]                 anOutReadValid;
    logic [ADDR_WIDTH-1:0]                     anOutMemoryAddr;
    logic                                      anOutMemoryEnable;
    logic [DATA_WIDTH-1:0]                     aMemoryData;
    logic                                      aMemoryValid;
    logic                                      anOutTimeoutError;

    modport slave (
        input  aRequest, aRequestAddr, aMemoryData, aMemoryValid,
        output anOutGrant, anOutReadData, anOutReadValid, anOutMemoryAddr,
               anOutMemoryEnable, anOutTimeoutError
    );

    modport master (
        output aRequest, aRequestAddr, aMemoryData, aMemoryValid,
        input  anOutGrant, anOutReadData, anOutReadValid, anOutMemoryAddr,
               anOutMemoryEnable, anOutTimeoutError
    );
endinterface

// File: rtl/memory_arbiter_picker.sv
// Combinational round-robin picker: first requester strictly after last_winner, wrapping.
module RoundRobinPicker
    import MemoryArbiterPkg::*;
#(
    parameter int NUM_REQUESTERS = 4
) (
    input  logic [NUM_REQUESTERS-1:0]         request,
    input  logic [$clog2(NUM_REQUESTERS)-1:0] last_winner,
    output logic [NUM_REQUESTERS-1:0]         grant,
    output logic                              grant_valid
);
    localparam int IDX_W = $clog2(NUM_REQUESTERS);

    int idx;

    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        idx         = next_index(int'(last_winner), NUM_REQUESTERS);
        for (int k = 0; k < NUM_REQUESTERS; k++) begin
            if (!grant_valid && request[IDX_W'(idx)]) begin
                grant[IDX_W'(idx)] = 1'b1;
                grant_valid        = 1'b1;
            end
            idx = next_index(idx, NUM_REQUESTERS);
        end
    end
endmodule

// File: rtl/memory_arbiter.sv
// Single-outstanding read arbiter: round-robin grant, one-cycle memory strobe,
// data return with a bounded wait and a sticky timeout flag.
module memory_arbiter
    import MemoryArbiterPkg::*;
#(
    parameter int NUM_REQUESTERS = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             aClock,
    input  logic             aReset,
    memory_arbiter_if.slave  bus
);
    localparam int                    IDX_W     = $clog2(NUM_REQUESTERS);
    localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_e state, state_next;

    logic [NUM_REQUESTERS-1:0] grant_q, read_valid_q, eligible, pick_grant;
    logic                      pick_valid;
    logic [IDX_W-1:0]          rr_ptr, last_winner, win_idx;
    logic [ADDR_WIDTH-1:0]     mem_addr_q;
    logic [DATA_WIDTH-1:0]     read_data_q;
    logic                      mem_en_q, timeout_q, timeout_hit;
    logic [WAIT_CNT_W-1:0]     wait_cnt;

    // A requester completing this cycle still has its request up; skip it.
    assign eligible    = bus.aRequest & ~read_valid_q;
    // rr_ptr is the first index to search; the picker wants the one before it.
    assign last_winner = (rr_ptr == '0) ? IDX_W'(NUM_REQUESTERS - 1) : rr_ptr - 1'b1;
    assign timeout_hit = (state == WAIT_DATA) && !bus.aMemoryValid && (wait_cnt == WAIT_LAST);

    RoundRobinPicker #(.NUM_REQUESTERS(NUM_REQUESTERS)) u_picker (
        .request     (eligible),
        .last_winner (last_winner),
        .grant       (pick_grant),
        .grant_valid (pick_valid)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NUM_REQUESTERS; i++)
            if (pick_grant[i]) win_idx = IDX_W'(i);
    end

    always_ff @(posedge aClock) begin
        if (aReset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (pick_valid) state_next = ISSUE;
            ISSUE:     state_next = WAIT_DATA;
            WAIT_DATA: if (bus.aMemoryValid || timeout_hit) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge aClock) begin
        if (aReset) begin
            grant_q      <= '0;
            read_valid_q <= '0;
            mem_addr_q   <= '0;
            read_data_q  <= '0;
            mem_en_q     <= 1'b0;
            timeout_q    <= 1'b0;
            wait_cnt     <= '0;
            rr_ptr       <= '0;
        end else begin
            read_valid_q <= '0;
            mem_en_q     <= 1'b0;
            case (state)
                IDLE: if (pick_valid) begin
                    grant_q    <= pick_grant;
                    mem_addr_q <= bus.aRequestAddr[win_idx];
                    mem_en_q   <= 1'b1;
                    rr_ptr     <= IDX_W'(next_index(int'(win_idx), NUM_REQUESTERS));
                end
                ISSUE: wait_cnt <= '0;
                WAIT_DATA: begin
                    // Real data beats a timeout landing in the same cycle.
                    if (bus.aMemoryValid) begin
                        read_data_q  <= bus.aMemoryData;
                        read_valid_q <= grant_q;
                        grant_q      <= '0;
                    end else if (timeout_hit) begin
                        read_data_q  <= '0;
                        read_valid_q <= grant_q;
                        grant_q      <= '0;
                        timeout_q    <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.anOutGrant        = grant_q;
    assign bus.anOutReadValid    = read_valid_q;
    assign bus.anOutMemoryAddr   = mem_addr_q;
    assign bus.anOutReadData     = read_data_q;
    assign bus.anOutMemoryEnable = mem_en_q;
    assign bus.anOutTimeoutError = timeout_q;
endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: directed scenarios then random transactions,
// checked against a transaction-level round-robin model.
module tb_memory_arbiter;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int T  = 4;

    logic aClock, aReset;
    memory_arbiter_if #(.NUM_REQUESTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    memory_arbiter #(.NUM_REQUESTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(T)) dut (
        .aClock (aClock),
        .aReset (aReset),
        .bus    (bus)
    );

    initial aClock = 1'b0;
    always #5 aClock = ~aClock;

    int         vectors = 0;
    int         miscompares = 0;
    int         m_start = 0;      // model: first index the next search tries
    logic [N-1:0] m_done = '0;    // model: requester completing in the current cycle
    bit         m_err = 1'b0;     // model: sticky timeout flag

    task automatic step();
        @(posedge aClock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_grant"},  64'(bus.anOutGrant), 0);
        chk({tag, "_valid"},  64'(bus.anOutReadValid), 0);
        chk({tag, "_enable"}, 64'(bus.anOutMemoryEnable), 0);
        chk({tag, "_addr"},   64'(bus.anOutMemoryAddr), 0);
        chk({tag, "_data"},   64'(bus.anOutReadData), 0);
        chk({tag, "_err"},    64'(bus.anOutTimeoutError), 0);
    endtask

    // One full read: starts in an Idle cycle, ends sampled in the valid-pulse cycle.
    // d = WaitData cycle index at which memory answers (d >= T means never).
    task automatic txn(input int d, input logic [DW-1:0] data, input bit drop);
        logic [N-1:0]  elig, own_oh;
        logic [AW-1:0] a;
        int            own;
        bit            to;
        elig = bus.aRequest & ~m_done;
        if (elig == '0) begin
            step();
            chk("idle_grant", 64'(bus.anOutGrant), 0);
            chk("idle_valid", 64'(bus.anOutReadValid), 0);
            m_done = '0;
            elig   = bus.aRequest;
        end
        own = -1;
        for (int k = 0; k < N; k++)
            if (own < 0 && elig[(m_start + k) % N]) own = (m_start + k) % N;
        if (own < 0) $fatal(1, "FAIL txn_setup no request present");
        own_oh = '0;
        own_oh[own] = 1'b1;
        a = bus.aRequestAddr[own];
        step();
        chk("issue_grant",  64'(bus.anOutGrant), 64'(own_oh));
        chk("issue_enable", 64'(bus.anOutMemoryEnable), 1);
        chk("issue_addr",   64'(bus.anOutMemoryAddr), 64'(a));
        chk("issue_valid",  64'(bus.anOutReadValid), 0);
        m_start = (own + 1) % N;
        m_done  = '0;
        // Memory answer during Issue must be ignored.
        bus.aMemoryValid = 1'b1;
        bus.aMemoryData  = 32'hDEAD_BEEF;
        step();
        bus.aMemoryValid = 1'b0;
        chk("wait_enable", 64'(bus.anOutMemoryEnable), 0);
        chk("wait_grant",  64'(bus.anOutGrant), 64'(own_oh));
        if (drop) bus.aRequest[own] = 1'b0;
        to = (d >= T);
        for (int w = 0; w < T; w++) begin
            if (w == d) begin
                bus.aMemoryValid = 1'b1;
                bus.aMemoryData  = data;
            end else begin
                bus.aMemoryData  = $urandom;
            end
            step();
            bus.aMemoryValid = 1'b0;
            if (w == d || w == T - 1) break;
            chk("hold_grant", 64'(bus.anOutGrant), 64'(own_oh));
            chk("hold_addr",  64'(bus.anOutMemoryAddr), 64'(a));
            chk("hold_valid", 64'(bus.anOutReadValid), 0);
        end
        m_err = m_err | to;
        chk("done_valid", 64'(bus.anOutReadValid), 64'(own_oh));
        chk("done_data",  64'(bus.anOutReadData), to ? 64'd0 : 64'(data));
        chk("done_grant", 64'(bus.anOutGrant), 0);
        chk("done_err",   64'(bus.anOutTimeoutError), 64'(m_err));
        m_done = own_oh;
    endtask

    initial begin
        aReset           = 1'b1;
        bus.aRequest     = '0;
        bus.aRequestAddr = '0;
        bus.aMemoryValid = 1'b0;
        bus.aMemoryData  = '0;
        step();
        step();
        chk_quiet("reset");
        aReset = 1'b0;

        // All four held: grants rotate 0,1,2,3,0.
        for (int i = 0; i < N; i++) bus.aRequestAddr[i] = $urandom;
        bus.aRequest = 4'b1111;
        for (int i = 0; i < 5; i++) txn($urandom_range(0, T - 1), $urandom, 1'b0);
        bus.aRequest = '0;

        // Single requester, data 3 cycles after the enable.
        bus.aRequestAddr[0] = 32'h100;
        bus.aRequest = 4'b0001;
        txn(2, 32'hCAFE, 1'b0);

        // Data coincident with the timeout cycle wins.
        txn(T - 1, 32'h1234_5678, 1'b0);
        bus.aRequest = '0;

        // Owner drops its request mid-transaction.
        bus.aRequest = 4'b0100;
        txn(1, 32'h0BAD_F00D, 1'b1);

        // Memory never answers: timeout, then a normal read still works.
        bus.aRequest = 4'b0010;
        txn(1000, 32'h5555_AAAA, 1'b0);
        txn(0, 32'h7777_1111, 1'b0);

        // Reset during WaitData, then a late memory answer.
        bus.aRequest = '0;
        step();
        chk("pre_rst_grant", 64'(bus.anOutGrant), 0);
        bus.aRequest = 4'b1000;
        step();
        chk("rst_txn_grant", 64'(bus.anOutGrant), 64'(4'b1000));
        step();
        step();
        aReset = 1'b1;
        step();
        aReset = 1'b0;
        bus.aMemoryValid = 1'b1;
        bus.aMemoryData  = 32'hFEED_FACE;
        bus.aRequest     = 4'b1001;
        chk_quiet("midrst");
        step();
        bus.aMemoryValid = 1'b0;
        chk("postrst_valid",  64'(bus.anOutReadValid), 0);
        chk("postrst_grant",  64'(bus.anOutGrant), 64'(4'b0001));
        chk("postrst_enable", 64'(bus.anOutMemoryEnable), 1);
        step();
        bus.aMemoryValid = 1'b1;
        bus.aMemoryData  = 32'h0000_ABCD;
        step();
        bus.aMemoryValid = 1'b0;
        chk("postrst_done_valid", 64'(bus.anOutReadValid), 64'(4'b0001));
        chk("postrst_done_data",  64'(bus.anOutReadData), 64'h0000_ABCD);
        m_start = 1;
        m_done  = 4'b0001;
        m_err   = 1'b0;

        // Random traffic.
        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < N; i++) bus.aRequestAddr[i] = $urandom;
            bus.aRequest = 4'($urandom_range(1, 15));
            txn($urandom_range(0, T + 1), $urandom, ($urandom_range(0, 3) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
